// File: rtl/dmem_pkg.sv
// Shared types, constants and the address check for the data-memory responder.
// Optional feature macro used across this slice: DMEM_WSTRB_EN (byte-lane stores).
package dmem_pkg;

  localparam int DMEM_WORD_W = 32;
  localparam int DMEM_CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  // An access is rejected when it is not word aligned or indexes past the array.
  function automatic logic dmem_addr_err(input logic [31:0] addr, input int unsigned depth);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth);
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bundle between the memory stage (master) and the responder (slave).
// Handshake: a beat moves on a rising edge where valid and ready are both high;
// the sender keeps valid and its payload stable until that edge, and ready may
// be driven without waiting for valid. With DMEM_WSTRB_EN defined the bundle
// also carries req_wstrb.
interface dmem_responder_if;
  import dmem_pkg::*;

  logic                   req_valid;
  logic                   req_ready;
  logic                   req_write;
  logic [DMEM_WORD_W-1:0] req_addr;
  logic [DMEM_WORD_W-1:0] req_wdata;
`ifdef DMEM_WSTRB_EN
  logic [3:0]             req_wstrb;
`endif
  logic                   resp_valid;
  logic                   resp_ready;
  logic [DMEM_WORD_W-1:0] resp_rdata;
  logic                   resp_err;

`ifdef DMEM_WSTRB_EN
  modport master (output req_valid, req_write, req_addr, req_wdata, req_wstrb, resp_ready,
                  input  req_ready, resp_valid, resp_rdata, resp_err);
  modport slave  (input  req_valid, req_write, req_addr, req_wdata, req_wstrb, resp_ready,
                  output req_ready, resp_valid, resp_rdata, resp_err);
`else
  modport master (output req_valid, req_write, req_addr, req_wdata, resp_ready,
                  input  req_ready, resp_valid, resp_rdata, resp_err);
  modport slave  (input  req_valid, req_write, req_addr, req_wdata, resp_ready,
                  output req_ready, resp_valid, resp_rdata, resp_err);
`endif

endinterface

// File: rtl/dmem_array.sv
// Synchronous single-port word array with byte-lane write enables and a
// registered read port. Word i powers up holding the value i; reset never
// touches the contents.
module dmem_array
  import dmem_pkg::*;
#(
  parameter  int DEPTH = 128,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   en,
  input  logic                   we,
  input  logic [IDX_W-1:0]       idx,
  input  logic [DMEM_WORD_W-1:0] wdata,
  input  logic [3:0]             wstrb,
  output logic [DMEM_WORD_W-1:0] rdata
);

  logic [DMEM_WORD_W-1:0] words [DEPTH];
  logic [DMEM_WORD_W-1:0] rdata_q;

  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    logic [DMEM_WORD_W-1:0] word_q = DMEM_WORD_W'(i);

    // Byte-lane store into this word when it is the addressed one.
    always_ff @(posedge clk) begin
      if (en && we && (idx == IDX_W'(i))) begin
        for (int k = 0; k < 4; k++) begin
          if (wstrb[k]) word_q[8*k +: 8] <= wdata[8*k +: 8];
        end
      end
    end

    assign words[i] = word_q;
  end

  // Load data is captured on the access edge and held until the next load.
  always_ff @(posedge clk) begin
    if (en && !we) rdata_q <= words[idx];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: accepts one load/store, waits a fixed
// number of cycles, touches the array on the edge that enters RESP, then
// presents the response until it is taken. Byte strobes exist only when
// DMEM_WSTRB_EN is defined; otherwise every store writes the full word.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH       = 128,
  parameter int WAIT_CYCLES = 2
) (
  input  logic           clk,
  input  logic           rst,
  dmem_responder_if.slave bus,
  output dmem_state_e    dbg_state
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [DMEM_CNT_W-1:0] WAIT_LD = DMEM_CNT_W'(WAIT_CYCLES);

  dmem_state_e            state_q, state_d;
  logic [DMEM_CNT_W-1:0]  cnt_q, cnt_d;
  logic                   accept, enter_resp;

  logic                   lat_write;
  logic [DMEM_WORD_W-1:0] lat_addr, lat_wdata;
  logic                   resp_err_q, rd_ok_q;

  logic                   acc_write, acc_err;
  logic [DMEM_WORD_W-1:0] acc_addr, acc_wdata;
  logic [3:0]             acc_wstrb;
  logic [DMEM_WORD_W-1:0] arr_rdata;

  // With zero wait states the array is accessed on the accept edge itself,
  // so the access fields come straight from the bus while in IDLE.
  assign acc_write = (state_q == IDLE) ? bus.req_write : lat_write;
  assign acc_addr  = (state_q == IDLE) ? bus.req_addr  : lat_addr;
  assign acc_wdata = (state_q == IDLE) ? bus.req_wdata : lat_wdata;
  assign acc_err   = dmem_addr_err(acc_addr, DEPTH);

`ifdef DMEM_WSTRB_EN
  logic [3:0] lat_wstrb;
  assign acc_wstrb = (state_q == IDLE) ? bus.req_wstrb : lat_wstrb;

  // Strobe latch, captured alongside the other request fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         lat_wstrb <= '0;
    else if (accept) lat_wstrb <= bus.req_wstrb;
  end
`else
  assign acc_wstrb = 4'hF;
`endif

  // Next-state and counter logic; the counter reloads on every accept.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    accept     = 1'b0;
    enter_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          accept = 1'b1;
          cnt_d  = WAIT_LD;
          if (WAIT_CYCLES > 0) begin
            state_d = WAIT;
          end else begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - DMEM_CNT_W'(1);
        if (cnt_q == DMEM_CNT_W'(1)) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP: begin
        if (bus.resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, request latch and response flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      lat_write  <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      resp_err_q <= 1'b0;
      rd_ok_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        lat_write <= bus.req_write;
        lat_addr  <= bus.req_addr;
        lat_wdata <= bus.req_wdata;
      end
      if (enter_resp) begin
        resp_err_q <= acc_err;
        rd_ok_q    <= !acc_err && !acc_write;
      end else if (state_q == RESP && bus.resp_ready) begin
        resp_err_q <= 1'b0;
        rd_ok_q    <= 1'b0;
      end
    end
  end

  dmem_array #(.DEPTH(DEPTH)) u_array (
    .clk   (clk),
    .en    (enter_resp && !acc_err),
    .we    (acc_write),
    .idx   (acc_addr[IDX_W+1:2]),
    .wdata (acc_wdata),
    .wstrb (acc_wstrb),
    .rdata (arr_rdata)
  );

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_rdata = rd_ok_q ? arr_rdata : '0;
  assign bus.resp_err   = resp_err_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed cases from the block's intent, then
// randomized loads/stores, all checked every cycle against a word-array model.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int DEPTH = 128;
  localparam int W     = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_state_e       dbg_state;
  dmem_responder_if  bus();

  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  logic [31:0] model_mem [DEPTH];
  logic [32:0] exp_q [$];   // {err, rdata}

  function automatic logic model_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a >> 2) >= 32'(DEPTH));
  endfunction

  logic        busy = 1'b0;
  int          ncyc = 0;
  int          due  = 0;
  logic        p_write;
  logic [31:0] p_addr, p_wdata;
  logic [3:0]  p_wstrb;

  // One compare process: expected outputs follow from "busy since accept,
  // response visible W+1 cycles after the accept cycle, array touched when
  // the response appears".
  always @(negedge clk) begin
    logic        e_valid;
    logic        perr;
    logic [31:0] pdata;
    int          idx;
    if (rst) begin
      busy = 1'b0;
      exp_q.delete();
      chk("rst_req_ready",  bus.req_ready,  1);
      chk("rst_resp_valid", bus.resp_valid, 0);
      chk("rst_resp_rdata", bus.resp_rdata, 0);
      chk("rst_resp_err",   bus.resp_err,   0);
      chk("rst_state",      dbg_state,      IDLE);
    end else begin
      if (busy && ncyc == due) begin
        perr  = model_err(p_addr);
        idx   = int'(p_addr >> 2);
        pdata = 32'h0;
        if (!perr && p_write) begin
          for (int k = 0; k < 4; k++)
            if (p_wstrb[k]) model_mem[idx][8*k +: 8] = p_wdata[8*k +: 8];
        end else if (!perr) begin
          pdata = model_mem[idx];
        end
        exp_q.push_back({perr, pdata});
      end
      e_valid = busy && (ncyc >= due);
      chk("req_ready",  bus.req_ready,  !busy);
      chk("resp_valid", bus.resp_valid, e_valid);
      chk("state", dbg_state, !busy ? IDLE : (e_valid ? RESP : WAIT));
      if (e_valid && exp_q.size() > 0) begin
        chk("resp_rdata", bus.resp_rdata, exp_q[0][31:0]);
        chk("resp_err",   bus.resp_err,   exp_q[0][32]);
      end
      if (!busy && bus.req_valid) begin
        busy    = 1'b1;
        due     = ncyc + W + 1;
        p_write = bus.req_write;
        p_addr  = bus.req_addr;
        p_wdata = bus.req_wdata;
`ifdef DMEM_WSTRB_EN
        p_wstrb = bus.req_wstrb;
`else
        p_wstrb = 4'hF;
`endif
      end else if (e_valid && bus.resp_ready) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        busy = 1'b0;
      end
    end
    ncyc++;
  end

  // ---------------- driver tasks ----------------
  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] strb, input int hold, input logic pre_ready,
                        output logic [31:0] rd, output logic er, output int lat);
    int t;
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
`ifdef DMEM_WSTRB_EN
    bus.req_wstrb = strb;
`else
    if (strb != 4'hF && wr) t = 0;
`endif
    t = 0;
    @(negedge clk);
    while (!bus.req_ready && t < 50) begin t++; @(negedge clk); end
    chk("req_accept", bus.req_ready, 1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'($urandom);
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;
    if (pre_ready) bus.resp_ready = 1'b1;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!bus.resp_valid && lat < 100);
    chk("resp_arrive", bus.resp_valid, 1);
    rd = bus.resp_rdata;
    er = bus.resp_err;
    repeat (hold) @(negedge clk);
    if (!pre_ready) begin @(posedge clk); #1 bus.resp_ready = 1'b1; end
    @(posedge clk); #1 bus.resp_ready = 1'b0;
  endtask

  task automatic load_chk(input string name, input logic [31:0] addr,
                          input logic [31:0] exp_d, input logic exp_e);
    logic [31:0] rd; logic er; int lat;
    do_req(1'b0, addr, 32'h0, 4'hF, 0, 1'b0, rd, er, lat);
    chk({name, "_rdata"}, rd, exp_d);
    chk({name, "_err"},   er, exp_e);
  endtask

  task automatic store_chk(input string name, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [3:0] strb, input logic exp_e);
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, addr, wd, strb, 0, 1'b0, rd, er, lat);
    chk({name, "_rdata"}, rd, 0);
    chk({name, "_err"},   er, exp_e);
  endtask

  // Watchdog: a hung handshake still produces a FAIL line.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] rd; logic er; int lat;
    logic [31:0] a;
    int r;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'(i);
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
`ifdef DMEM_WSTRB_EN
    bus.req_wstrb  = 4'hF;
`endif
    bus.resp_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Plain load: word 4, three cycles from the accept cycle.
    do_req(1'b0, 32'h10, 32'h0, 4'hF, 0, 1'b0, rd, er, lat);
    chk("load10_rdata", rd, 32'd4);
    chk("load10_err",   er, 0);
    chk("load10_latency", lat, 3);

    // Store then read back; neighbours untouched.
    store_chk("st20", 32'h20, 32'hDEADBEEF, 4'hF, 1'b0);
    load_chk("ld20", 32'h20, 32'hDEADBEEF, 1'b0);
    load_chk("ld1c", 32'h1C, 32'd7, 1'b0);
    load_chk("ld24", 32'h24, 32'd9, 1'b0);

    // Errors: misaligned, out of range, and a rejected store.
    load_chk("ld22_mis",   32'h22,  32'h0, 1'b1);
    load_chk("ld200_oor",  32'h200, 32'h0, 1'b1);
    load_chk("ld1fc_last", 32'h1FC, 32'd127, 1'b0);
    store_chk("st22_mis", 32'h22, 32'hFFFFFFFF, 4'hF, 1'b1);
    load_chk("ld20_after_err", 32'h20, 32'hDEADBEEF, 1'b0);

    // Response held for five cycles, then released.
    do_req(1'b0, 32'h0C, 32'h0, 4'hF, 5, 1'b0, rd, er, lat);
    chk("hold_rdata", rd, 32'd3);
    @(negedge clk);
    chk("hold_release_state", dbg_state, IDLE);
    chk("hold_release_ready", bus.req_ready, 1);

    // resp_ready already high: one-cycle response.
    do_req(1'b0, 32'h14, 32'h0, 4'hF, 0, 1'b1, rd, er, lat);
    chk("pre_ready_rdata", rd, 32'd5);

    // Reset during the wait of a store discards it.
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_write = 1'b1;
    bus.req_addr  = 32'h30; bus.req_wdata = 32'h55;
`ifdef DMEM_WSTRB_EN
    bus.req_wstrb = 4'hF;
`endif
    @(negedge clk);
    chk("rst_test_accept", bus.req_ready, 1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("rst_test_in_wait", dbg_state, WAIT);
    rst = 1'b1;
    #1;
    chk("rst_async_valid", bus.resp_valid, 0);
    chk("rst_async_state", dbg_state, IDLE);
    repeat (2) @(negedge clk);
    @(posedge clk); #2 rst = 1'b0;
    load_chk("ld30_after_rst", 32'h30, 32'd12, 1'b0);

`ifdef DMEM_WSTRB_EN
    store_chk("st04_strb", 32'h04, 32'hAABBCCDD, 4'b0101, 1'b0);
    load_chk("ld04_strb", 32'h04, 32'h00BB00DD, 1'b0);
    store_chk("st08_nostrb", 32'h08, 32'h12345678, 4'b0000, 1'b0);
    load_chk("ld08_nostrb", 32'h08, 32'd2, 1'b0);
`endif

    // Randomized traffic, checked by the compare process.
    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      a = (32'($urandom_range(0, DEPTH-1)) << 2) | 32'($urandom_range(1, 3));
      else if (r == 1) a = 32'($urandom_range(DEPTH, 4*DEPTH)) << 2;
      else if (r < 6)  a = 32'($urandom_range(0, 15)) << 2;
      else             a = 32'($urandom_range(0, DEPTH-1)) << 2;
      do_req(1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 3),
             1'($urandom_range(0, 3) == 0), rd, er, lat);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
